// File: rtl/serin_shift_module.sv
// Serial-input shift path for the POKEY core. It samples SerIn once per bit,
// assembles 8 data bits LSB first, loads SERIN at the stop bit and keeps the
// Full / Overrun / FrameErr status flags.
module serin_shift_module (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enp,
  input  logic       enn,
  input  logic       SerIn,
  input  logic       Shift,
  input  logic       AddrDr,
  input  logic       SkRes,
  output logic [7:0] Dout,
  output logic       Full,
  output logic       Overrun,
  output logic       FrameErr,
  output logic       Busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   shreg;
  logic [CW-1:0]   bitcnt;
  logic            sample_c;
  logic            xfer_c;
  logic            rd_c;
  logic            skres_c;
  logic            unused_enn;

  // enn only paces the transmit side; it is kept for port symmetry
  assign unused_enn = enn;

  // One sample event per slow-clock period; CPU controls act only on enp cycles
  assign sample_c = enp & Shift;
  assign xfer_c   = sample_c & (state == STOP);
  assign rd_c     = enp & AddrDr;
  assign skres_c  = enp & SkRes;

  // Busy decodes the registered state
  assign Busy = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start bit -> 8 data bits -> stop bit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sample_c && !SerIn) state_nxt = DATA;
      DATA: if (sample_c && (bitcnt == CW'(7))) state_nxt = STOP;
      STOP: if (sample_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter; bitcnt holds at 7 so it never wraps in a frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (sample_c) begin
      if (state == IDLE && !SerIn) begin
        bitcnt <= '0;
      end else if (state == DATA) begin
        shreg <= {SerIn, shreg[DW-1:1]};
        if (bitcnt != CW'(7)) begin
          bitcnt <= bitcnt + CW'(1);
        end
      end
    end
  end

  // Holding register and status flags; a set beats a same-cycle clear,
  // and a read in the transfer cycle is taken as read-then-transfer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Dout     <= '0;
      Full     <= 1'b0;
      Overrun  <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      if (xfer_c) begin
        Dout <= shreg;
        Full <= 1'b1;
      end else if (rd_c) begin
        Full <= 1'b0;
      end

      if (xfer_c && Full && !AddrDr) begin
        Overrun <= 1'b1;
      end else if (skres_c) begin
        Overrun <= 1'b0;
      end

      if (xfer_c && !SerIn) begin
        FrameErr <= 1'b1;
      end else if (skres_c) begin
        FrameErr <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serin_shift_module.md
# serin_shift_module

Serial-input shift module for the POKEY core: the receive-side counterpart of the SEROUT shift/transmit path. It samples the serial input line once per bit period, detects the start bit and shifts in 8 data bits LSB first. At the stop bit it transfers the assembled byte into the SERIN holding register and raises the serial-input-data-ready flag toward the IRQ logic. It also maintains the overrun and framing-error status bits reported through SKSTAT.

## Interface
Parameters: none.

- clk  input  1  50 MHz system clock; all logic on posedge clk.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- enp  input  1  one-clk pulse at each rising edge of the 1.79 MHz slow clock.
- enn  input  1  one-clk pulse at each falling edge of the 1.79 MHz slow clock; not used for state updates, provided for port symmetry with the transmit module.
- SerIn  input  1  serial input line, already synchronized to clk; idle high.
- Shift  input  1  bit-sample request from the channel timer logic; held for about one slow-clock period per bit.
- AddrDr  input  1  CPU read of the SERIN register; clears Full.
- SkRes  input  1  CPU write to SKRES; clears Overrun and FrameErr.
- Dout  output  8  SERIN holding register.
- Full  output  1  received-byte-ready flag (IRQ source).
- Overrun  output  1  sticky flag: a byte was transferred while Full was already set.
- FrameErr  output  1  sticky flag: the stop bit was sampled low.
- Busy  output  1  high whenever the FSM is not IDLE.

## Operation
- **Sample event:** a clk cycle with enp=1 and Shift=1. Shift without enp is ignored. At most one event occurs per slow-clock period.
- **Control event:** AddrDr or SkRes is acted on only in clk cycles with enp=1.
- **FSM states:**
  - IDLE
    - Sample event with SerIn=0: go to DATA and clear bitcnt.
    - SerIn=1: stay in IDLE.
  - DATA
    - Each sample event: shreg <= {SerIn, shreg[7:1]} and bitcnt <= bitcnt+1.
    - On the 8th event (bitcnt==7): go to STOP.
  - STOP
    - Next sample event: Dout <= shreg and Full <= 1.
    - If SerIn=0, set FrameErr. The byte is still transferred.
    - Go to IDLE.
- **bitcnt:** 3 bits, cleared on entry to DATA, never wraps within a frame.
- **Overrun:** set when the transfer occurs while Full=1 and no AddrDr is present in the same cycle. Dout is overwritten with the new byte.
- **Read/transfer collision:** AddrDr in the same cycle as a transfer is processed as read-then-transfer. Full ends at 1 and Overrun is not set.
- **SkRes collision:** SkRes in the same cycle as an error-setting condition: the set wins and the flag ends at 1.
- **Busy:** combinational decode of state != IDLE.
- **Reset (reset_n=0 at posedge clk), including mid-frame:**
  - State goes to IDLE; shreg, bitcnt and Dout go to 0x00.
  - Full, Overrun and FrameErr go to 0; Busy=0.
  - A partial frame is discarded.

## Timing
- All registers update at the posedge clk that ends the enp cycle. Outputs are valid from the following clk cycle.
- Frame = 10 sample events: start, 8 data, stop.
- Full, Dout, FrameErr and Overrun change at the edge closing the stop-bit sample event. This is a latency of 1 clk after that event.
- Full falls 1 clk after the enp cycle carrying AddrDr. Overrun and FrameErr fall 1 clk after the enp cycle carrying SkRes.
- Busy rises 1 clk after the start-bit sample and falls 1 clk after the stop-bit sample.
- Reset values: Dout=0x00, Full=0, Overrun=0, FrameErr=0, Busy=0.

## Test plan
Shift is pulsed per bit as the transmit bench does: asserted after enn, deasserted one slow-clock period later.

1. **Normal byte:** serial 0,1,0,0,1,0,0,1,1,1 (start, 0xC9 LSB first, stop) -> Dout=0xC9, Full=1, FrameErr=0, Overrun=0, Busy back to 0. Then AddrDr -> Full=0 and Dout holds 0xC9.
2. **Framing error:** 0x3C sent with the stop bit 0 -> Dout=0x3C, Full=1, FrameErr=1. Then SkRes -> FrameErr=0 and Full stays 1.
3. **Overrun:** 0xA5 then 0x5A with no AddrDr -> Dout=0x5A, Full=1, Overrun=1. Then SkRes -> Overrun=0.
4. **Read/transfer collision:** AddrDr coincident with the stop-bit sample of 0x81 while Full=1 -> Dout=0x81, Full=1, Overrun=0.
5. **Idle and gating:**
   - SerIn=1 for 20 sample events -> Busy=0, Full=0.
   - Shift=1 and SerIn=0 for clk cycles with enp=0 only -> no state change.
6. **Reset mid-frame:** reset_n=0 for 1 clk after 4 data bits -> all outputs 0. The next full frame 0x5A is received correctly with no FrameErr.
